soundrive_regs: RTL and testbench

- Upstream feeder of the audio mixer.
- Captures Z80 I/O writes to the Soundrive channel ports and holds four 8-bit sample registers.
- Drives sd_l0/sd_l1/sd_r0/sd_r1 through a shared click-free soft-mute attenuator.
- All logic is in the clk28 domain; asynchronous CPU bus strobes are synchronised internally.

---
 rtl/sound_pkg.sv | 37 +++
 rtl/soundrive_regs_bus_sync.sv | 23 ++
 rtl/soundrive_regs.sv | 186 ++++++++++++++++++
 tb/tb_soundrive_regs.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and constants for the Soundrive register block.
package sound_pkg;

  // Gain state of the shared soft-mute attenuator.
  typedef enum logic [1:0] {
    MUTED  = 2'd0,
    UNMUTE = 2'd1,
    ACTIVE = 2'd2,
    MUTE   = 2'd3
  } gain_state_t;

  // CPU write capture sequencer.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CAPTURE      = 2'd1,
    WAIT_RELEASE = 2'd2
  } wr_state_t;

  // Default low-address-byte port decodes.
  localparam logic [7:0] DEF_PORT_L0    = 8'h0F;
  localparam logic [7:0] DEF_PORT_L1    = 8'h1F;
  localparam logic [7:0] DEF_PORT_R0    = 8'h4F;
  localparam logic [7:0] DEF_PORT_R1    = 8'h5F;
  localparam logic [7:0] DEF_COVOX_PORT = 8'hFB;

  // Attenuation is a right shift; SHIFT_MAX clears an 8-bit sample.
  localparam int SHIFT_MAX = 8;
  localparam int NUM_CH    = 4;

  // Snapshot of both FSMs and the current attenuation.
  typedef struct packed {
    gain_state_t gain;
    wr_state_t   wr;
    logic [3:0]  shift;
  } dbg_t;

endpackage

// File: rtl/soundrive_regs_bus_sync.sv
// Two-flop synchroniser for one asynchronous, active-low Z80 bus strobe.
// Resets to 1 so a strobe reads as inactive while reset is applied.
module bus_sync (
  input  logic clk28,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  // Shift the raw strobe through two flops into the clk28 domain.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/soundrive_regs.sv
// Soundrive channel registers with shared click-free soft-mute attenuator.
// Optional build macro COVOX_FB_EN: a write to COVOX_PORT loads all four
// channel registers at once; without it that port is not decoded.
//
// Handshake: there is no valid/ready pair here. A CPU write is one bus
// cycle where IORQ and WR are low and M1 is high; it is taken exactly once,
// on the edge the synchronised strobe is first seen active, and the next
// write is accepted only after the strobe has been seen inactive again.
module soundrive_regs
  import sound_pkg::*;
#(
  parameter int         RAMP_DIV   = 4096,
  parameter logic [7:0] PORT_L0    = DEF_PORT_L0,
  parameter logic [7:0] PORT_L1    = DEF_PORT_L1,
  parameter logic [7:0] PORT_R0    = DEF_PORT_R0,
`ifdef COVOX_FB_EN
  parameter logic [7:0] PORT_R1    = DEF_PORT_R1,
  parameter logic [7:0] COVOX_PORT = DEF_COVOX_PORT
`else
  parameter logic [7:0] PORT_R1    = DEF_PORT_R1
`endif
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       en,
  input  logic [7:0] bus_a,
  input  logic [7:0] bus_d,
  input  logic       bus_iorq_n,
  input  logic       bus_wr_n,
  input  logic       bus_m1_n,
  output logic [7:0] sd_l0,
  output logic [7:0] sd_l1,
  output logic [7:0] sd_r0,
  output logic [7:0] sd_r1,
  output logic       muted,
  output dbg_t       dbg
);

  localparam int         PW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [3:0] S_MAX = 4'(SHIFT_MAX);

  logic iorq_s, wr_s, m1_s;
  logic wr_act;

  wr_state_t                    wr_state;
  logic [NUM_CH-1:0][7:0]       ch_reg;
  logic [NUM_CH-1:0]            hit;

  gain_state_t                  gain_state;
  logic [3:0]                   shift;
  logic [PW-1:0]                pre;
  logic                         tick;
  logic [NUM_CH-1:0][7:0]       sd_q;

  bus_sync u_sync_iorq (.clk28(clk28), .rst_n(rst_n), .din(bus_iorq_n), .dout(iorq_s));
  bus_sync u_sync_wr   (.clk28(clk28), .rst_n(rst_n), .din(bus_wr_n),   .dout(wr_s));
  bus_sync u_sync_m1   (.clk28(clk28), .rst_n(rst_n), .din(bus_m1_n),   .dout(m1_s));

  // Interrupt acknowledge (M1 low) never counts as an I/O write.
  assign wr_act = !iorq_s && !wr_s && m1_s;

  // Full 8-bit port decode of the address held on the bus.
  always_comb begin
    hit    = '0;
    hit[0] = (bus_a == PORT_L0);
    hit[1] = (bus_a == PORT_L1);
    hit[2] = (bus_a == PORT_R0);
    hit[3] = (bus_a == PORT_R1);
`ifdef COVOX_FB_EN
    if (bus_a == COVOX_PORT) hit = '1;
`endif
  end

  // Write sequencer: the register load happens on the edge that enters
  // CAPTURE, so a register changes on the 3rd clk28 edge after the pins
  // go active; WAIT_RELEASE blocks repeats while the strobe is held.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= IDLE;
      ch_reg   <= '0;
    end else begin
      case (wr_state)
        IDLE: begin
          if (wr_act) begin
            wr_state <= CAPTURE;
            for (int i = 0; i < NUM_CH; i++) begin
              if (hit[i]) ch_reg[i] <= bus_d;
            end
          end
        end
        CAPTURE:      wr_state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!wr_act) wr_state <= IDLE;
        default:      wr_state <= IDLE;
      endcase
    end
  end

  assign tick = (pre == PW'(RAMP_DIV - 1));

  // Gain FSM: shift walks one step per prescaler tick toward 0 (en) or
  // SHIFT_MAX (!en). A reversal keeps the current shift; if the ramp is
  // reversed while still at its starting end, the FSM goes straight to
  // the matching rest state instead of ramping from there.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      gain_state <= MUTED;
      shift      <= S_MAX;
      pre        <= '0;
      muted      <= 1'b1;
    end else begin
      case (gain_state)
        MUTED: begin
          if (en) begin
            gain_state <= UNMUTE;
            pre        <= '0;
            muted      <= 1'b0;
          end
        end
        UNMUTE: begin
          if (!en) begin
            pre <= '0;
            if (shift == S_MAX) begin
              gain_state <= MUTED;
              muted      <= 1'b1;
            end else begin
              gain_state <= MUTE;
            end
          end else if (tick) begin
            pre   <= '0;
            shift <= shift - 4'd1;
            if (shift == 4'd1) gain_state <= ACTIVE;
          end else begin
            pre <= pre + PW'(1);
          end
        end
        ACTIVE: begin
          if (!en) begin
            gain_state <= MUTE;
            pre        <= '0;
          end
        end
        MUTE: begin
          if (en) begin
            pre <= '0;
            if (shift == 4'd0) gain_state <= ACTIVE;
            else               gain_state <= UNMUTE;
          end else if (tick) begin
            pre   <= '0;
            shift <= shift + 4'd1;
            if (shift == S_MAX - 4'd1) begin
              gain_state <= MUTED;
              muted      <= 1'b1;
            end
          end else begin
            pre <= pre + PW'(1);
          end
        end
        default: begin
          gain_state <= MUTED;
          shift      <= S_MAX;
          pre        <= '0;
          muted      <= 1'b1;
        end
      endcase
    end
  end

  // Registered attenuated outputs; a shift of 8 zero-fills the sample.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) sd_q[i] <= ch_reg[i] >> shift;
    end
  end

  assign sd_l0 = sd_q[0];
  assign sd_l1 = sd_q[1];
  assign sd_r0 = sd_q[2];
  assign sd_r1 = sd_q[3];

  assign dbg.gain  = gain_state;
  assign dbg.wr    = wr_state;
  assign dbg.shift = shift;

endmodule

// File: tb/tb_soundrive_regs.sv
// Bench for soundrive_regs: directed scenarios plus randomized writes and
// enable toggling, compared against a cycle-level behavioural model.
module tb_soundrive_regs;
  import sound_pkg::*;

  localparam int R = 32;

  logic       rst_n, clk28, en;
  logic [7:0] bus_a, bus_d;
  logic       bus_iorq_n, bus_wr_n, bus_m1_n;
  logic [7:0] sd_l0, sd_l1, sd_r0, sd_r1;
  logic       muted;
  dbg_t       dbg;

  int n_checks = 0;
  int n_errors = 0;

  soundrive_regs #(.RAMP_DIV(R)) dut (
    .rst_n(rst_n), .clk28(clk28), .en(en), .bus_a(bus_a), .bus_d(bus_d),
    .bus_iorq_n(bus_iorq_n), .bus_wr_n(bus_wr_n), .bus_m1_n(bus_m1_n),
    .sd_l0(sd_l0), .sd_l1(sd_l1), .sd_r0(sd_r0), .sd_r1(sd_r1),
    .muted(muted), .dbg(dbg)
  );

  // ---------------- clock ----------------
  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Registers change on the 3rd edge the write pins are seen active; the
  // shift moves one step toward its target (0 when enabled, 8 when not)
  // after every R edges of uninterrupted movement; outputs show
  // register >> shift one edge later.
  logic [7:0] m_reg [4];
  logic [7:0] m_sd  [4];
  int         m_s, m_timer, m_prev_tgt, act_cnt;
  logic       m_muted;

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    case (a)
      8'h0F: m_reg[0] = d;
      8'h1F: m_reg[1] = d;
      8'h4F: m_reg[2] = d;
      8'h5F: m_reg[3] = d;
`ifdef COVOX_FB_EN
      8'hFB: for (int i = 0; i < 4; i++) m_reg[i] = d;
`endif
      default: ;
    endcase
  endtask

  always @(posedge clk28 or negedge rst_n) begin
    int tgt;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[i] = 8'h00;
        m_sd[i]  = 8'h00;
      end
      m_s = 8; m_timer = 0; m_prev_tgt = 8; act_cnt = 0; m_muted = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) m_sd[i] = m_reg[i] >> m_s;
      if (!bus_iorq_n && !bus_wr_n && bus_m1_n) begin
        act_cnt++;
        if (act_cnt == 3) model_write(bus_a, bus_d);
      end else begin
        act_cnt = 0;
      end
      tgt = en ? 0 : 8;
      if (m_s == tgt || tgt != m_prev_tgt) begin
        m_timer = 0;
      end else begin
        m_timer++;
        if (m_timer == R) begin
          m_s     = (tgt > m_s) ? m_s + 1 : m_s - 1;
          m_timer = 0;
        end
      end
      m_prev_tgt = tgt;
      m_muted    = (m_s == 8) && (tgt == 8);
    end
  end

  // Cycle-by-cycle scoreboard of all outputs against the model.
  always @(negedge clk28) begin
    if (rst_n)
      chk("outs", {muted, sd_l0, sd_l1, sd_r0, sd_r1},
          {m_muted, m_sd[0], m_sd[1], m_sd[2], m_sd[3]});
  end

  // ---------------- drivers ----------------
  task automatic io_write(input logic [7:0] a, input logic [7:0] d,
                          input logic m1, input int hold);
    @(posedge clk28); #1;
    bus_a = a; bus_d = d; bus_m1_n = m1; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (hold) @(posedge clk28);
    #1;
    bus_iorq_n = 1'b1; bus_wr_n = 1'b1; bus_m1_n = 1'b1;
    repeat (4) @(posedge clk28);
  endtask

  task automatic set_en(input logic v);
    @(posedge clk28); #1;
    en = v;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] exp);
    chk(tag, {sd_l0, sd_l1, sd_r0, sd_r1}, exp);
  endtask

  logic [7:0] ramp_tbl [9] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h52, 8'hA5};
  logic [7:0] addr_tbl [7] = '{8'h0F, 8'h1F, 8'h4F, 8'h5F, 8'hFB, 8'h0E, 8'h1E};

`ifdef COVOX_FB_EN
  localparam logic [31:0] EXP_FB = 32'h33333333;
`else
  localparam logic [31:0] EXP_FB = 32'hA5008000;
`endif

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; bus_a = 8'h00; bus_d = 8'h00;
    bus_iorq_n = 1'b1; bus_wr_n = 1'b1; bus_m1_n = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk28);
    #1;
    chk_all("rst_sd", 32'h0);
    chk("rst_muted", muted, 1'b1);
    chk("rst_gain", dbg.gain, MUTED);
    chk("rst_wr", dbg.wr, IDLE);
    chk("rst_shift", dbg.shift, 4'd8);
    @(posedge clk28); #1;
    rst_n = 1'b1;

    // Write while muted: register takes it, output stays silent.
    io_write(8'h0F, 8'hA5, 1'b1, 4);
    chk("reg_l0", dut.ch_reg[0], 8'hA5);
    chk("muted_sd_l0", sd_l0, 8'h00);
    chk("muted_flag", muted, 1'b1);

    // Unmute ramp, one step every R cycles.
    set_en(1'b1);
    @(posedge clk28);
    @(negedge clk28);
    chk("unmute_entry", muted, 1'b0);
    @(posedge clk28);
    @(negedge clk28);
    chk("ramp0", sd_l0, ramp_tbl[0]);
    for (int k = 1; k < 9; k++) begin
      repeat (R) @(posedge clk28);
      @(negedge clk28);
      chk($sformatf("ramp%0d", k), sd_l0, ramp_tbl[k]);
    end

    // Write latency and single write per held strobe.
    @(posedge clk28); #1;
    bus_a = 8'h4F; bus_d = 8'h80; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    repeat (3) @(posedge clk28);
    @(negedge clk28);
    chk("lat_e3", sd_r0, 8'h00);
    @(posedge clk28);
    @(negedge clk28);
    chk("lat_e4", sd_r0, 8'h80);
    bus_d = 8'h11;
    repeat (16) @(posedge clk28);
    #1;
    bus_iorq_n = 1'b1; bus_wr_n = 1'b1;
    repeat (4) @(posedge clk28);
    chk("one_write", sd_r0, 8'h80);

    // Ignored writes: interrupt acknowledge and near-miss addresses.
    io_write(8'h0F, 8'h77, 1'b0, 5);
    io_write(8'h0E, 8'h77, 1'b1, 5);
    io_write(8'h1E, 8'h77, 1'b1, 5);
    chk_all("ignored", 32'hA5008000);

    // Covox port.
    io_write(8'hFB, 8'h33, 1'b1, 4);
    chk_all("covox", EXP_FB);
    io_write(8'h0F, 8'hA5, 1'b1, 3);

    // Reversal mid-ramp.
    set_en(1'b0);
    @(posedge clk28);
    repeat (R) @(posedge clk28);
    @(posedge clk28);
    @(negedge clk28);
    chk("rev_s1", sd_l0, 8'h52);
    repeat (R) @(posedge clk28);
    @(negedge clk28);
    chk("rev_s2", sd_l0, 8'h29);
    repeat (R/2 - 2) @(posedge clk28);
    #1;
    en = 1'b1;
    @(posedge clk28);
    @(negedge clk28);
    chk("rev_hold", sd_l0, 8'h29);
    repeat (R) @(posedge clk28);
    @(posedge clk28);
    @(negedge clk28);
    chk("rev_back1", sd_l0, 8'h52);
    repeat (R) @(posedge clk28);
    @(negedge clk28);
    chk("rev_back0", sd_l0, 8'hA5);

    // Asynchronous reset mid-ramp and mid-write.
    set_en(1'b0);
    repeat (R + R/2) @(posedge clk28);
    @(negedge clk28);
    chk("pre_rst", sd_l0, 8'h52);
    @(posedge clk28); #1;
    bus_a = 8'h1F; bus_d = 8'h99; bus_iorq_n = 1'b0; bus_wr_n = 1'b0;
    @(posedge clk28); #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async_sd", 32'h0);
    chk("rst_async_muted", muted, 1'b1);
    chk("rst_async_gain", dbg.gain, MUTED);
    #1;
    bus_iorq_n = 1'b1; bus_wr_n = 1'b1;
    repeat (3) @(posedge clk28);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk28);
    chk("lost_wr", dut.ch_reg[1], 8'h00);

    // Randomized writes and enable toggling, checked by the scoreboard.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        logic [7:0] a;
        a = ($urandom_range(0, 7) == 7) ? 8'($urandom) : addr_tbl[$urandom_range(0, 6)];
        io_write(a, 8'($urandom), ($urandom_range(0, 5) != 0), $urandom_range(3, 10));
      end else begin
        set_en(1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 3 * R)) @(posedge clk28);
      end
    end
    set_en(1'b1);
    repeat (9 * R + 4) @(posedge clk28);
    @(negedge clk28);
    chk("final_unmuted", muted, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
